// File: rtl/serial_link_pkg.sv
// serial_link_pkg: frame layout and receiver states shared by both ends of the serial link
package serial_link_pkg;
  localparam int BYTE_BITS = 8;
  function automatic int frame_bits(input int data_w);
    return data_w + data_w / BYTE_BITS;
  endfunction
  typedef enum logic [1:0] {RECV, RESP, REPLY} sipo_state_t;
endpackage

// File: rtl/sipo_parity_acc.sv
// sipo_parity_acc: per-byte XOR accumulator flagging a parity bit that disagrees with its byte
module sipo_parity_acc (
  input  logic clk_i,
  input  logic reset_i,
  input  logic sbit,
  input  logic valid,
  input  logic is_parity_slot,
  input  logic clr,
  output logic mismatch
);
  logic acc;
  // running XOR of the current byte, restarted after every parity slot or frame end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) acc <= 1'b0;
    else if (clr || (valid && is_parity_slot)) acc <= 1'b0;
    else if (valid) acc <= acc ^ sbit;
  assign mismatch = valid && is_parity_slot && (sbit != acc);
endmodule

// File: rtl/sipo_receiver.sv
// sipo_receiver: deserialises parity-protected frames, answers ack/nack, presents words on valid/ready
module sipo_receiver
  import serial_link_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int RESP_LAT = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              s_i,
  input  logic              valid_i,
  input  logic              last_i,
  output logic              ack_o,
  output logic              nack_o,
  output logic [DATA_W-1:0] p_o,
  output logic              valid_o,
  input  logic              rdy_i,
  output logic              err_parity_o,
  output logic              err_frame_o,
  output logic              err_ovf_o
);
  localparam int FB = frame_bits(DATA_W);
  localparam int IW = $clog2(FB);
  localparam int DW = $clog2(DATA_W);
  sipo_state_t state, state_n;
  logic [IW-1:0] idx;
  logic [3:0] pos;
  logic [DW-1:0] ds;
  logic [2:0] dly;
  logic [DATA_W-1:0] sr;
  logic perr, ferr;
  logic samp, par_slot, at_end, fin, mis, fire, bad, ok;
  assign samp = state == RECV && valid_i;
  assign par_slot = pos == 4'd8;
  assign at_end = idx == IW'(FB - 1);
  assign fin = samp && (last_i || at_end);
  assign fire = state == RESP && dly == 3'd0;
  assign bad = perr || ferr;
  assign ok = fire && !bad && (!valid_o || rdy_i);
  sipo_parity_acc u_acc (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .sbit(s_i),
    .valid(samp),
    .is_parity_slot(par_slot),
    .clr(fin),
    .mismatch(mis)
  );
  // next state: receive until frame end, wait out the response delay, reply for one cycle
  always_comb begin
    state_n = state;
    state_n = state == RECV ? (fin ? RESP : RECV) : state == RESP ? (fire ? REPLY : RESP) : RECV;
  end
  // state register and response delay countdown
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state <= RECV;
      dly <= 3'd0;
    end else begin
      state <= state_n;
      if (fin) dly <= 3'(RESP_LAT - 1);
      else if (state == RESP && dly != 3'd0) dly <= dly - 3'd1;
    end
  // frame bit index, position within the 9-bit byte group, and data slot
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      idx <= '0;
      pos <= '0;
      ds <= '0;
    end else if (fin) begin
      idx <= '0;
      pos <= '0;
      ds <= '0;
    end else if (samp) begin
      idx <= idx + 1'b1;
      pos <= par_slot ? 4'd0 : pos + 4'd1;
      ds <= par_slot ? ds : ds + 1'b1;
    end
  // data bits land at their slot; parity bits are not stored
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) sr <= '0;
    else if (samp && !par_slot) sr[ds] <= s_i;
  // sticky parity and framing errors, held until the reply consumes them
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      perr <= 1'b0;
      ferr <= 1'b0;
    end else begin
      perr <= fire ? 1'b0 : perr || mis;
      ferr <= fire ? 1'b0 : ferr || (fin && (last_i != at_end));
    end
  // reply pulses and output register; a drain and a reload may share a cycle
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      ack_o <= 1'b0;
      nack_o <= 1'b0;
      err_parity_o <= 1'b0;
      err_frame_o <= 1'b0;
      err_ovf_o <= 1'b0;
      valid_o <= 1'b0;
      p_o <= '0;
    end else begin
      ack_o <= ok;
      nack_o <= fire && !ok;
      err_parity_o <= fire && perr;
      err_frame_o <= fire && ferr;
      err_ovf_o <= fire && !bad && !ok;
      valid_o <= ok || (valid_o && !rdy_i);
      if (ok) p_o <= sr;
    end
endmodule
